// File: rtl/ctrl_pkg.sv
// Shared definitions for the WISC control pipeline: opcodes,
// control bundle layout, reg_dst encodings and halt FSM states.
package ctrl_pkg;

    localparam int OP_W   = 5;
    localparam int WREG_W = 3;
    localparam int CTRL_W = 22;

    // Opcodes (instruction bits [15:11])
    localparam logic [OP_W-1:0] OP_HALT  = 5'b00000;
    localparam logic [OP_W-1:0] OP_NOP   = 5'b00001;
    localparam logic [OP_W-1:0] OP_SIIC  = 5'b00010;
    localparam logic [OP_W-1:0] OP_RTI   = 5'b00011;
    localparam logic [OP_W-1:0] OP_J     = 5'b00100;
    localparam logic [OP_W-1:0] OP_JR    = 5'b00101;
    localparam logic [OP_W-1:0] OP_JAL   = 5'b00110;
    localparam logic [OP_W-1:0] OP_JALR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SUBI  = 5'b01001;
    localparam logic [OP_W-1:0] OP_XORI  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ANDNI = 5'b01011;
    localparam logic [OP_W-1:0] OP_BEQZ  = 5'b01100;
    localparam logic [OP_W-1:0] OP_BNEZ  = 5'b01101;
    localparam logic [OP_W-1:0] OP_BLTZ  = 5'b01110;
    localparam logic [OP_W-1:0] OP_BGEZ  = 5'b01111;
    localparam logic [OP_W-1:0] OP_ST    = 5'b10000;
    localparam logic [OP_W-1:0] OP_LD    = 5'b10001;
    localparam logic [OP_W-1:0] OP_SLBI  = 5'b10010;
    localparam logic [OP_W-1:0] OP_STU   = 5'b10011;
    localparam logic [OP_W-1:0] OP_ROLI  = 5'b10100;
    localparam logic [OP_W-1:0] OP_SLLI  = 5'b10101;
    localparam logic [OP_W-1:0] OP_RORI  = 5'b10110;
    localparam logic [OP_W-1:0] OP_SRLI  = 5'b10111;
    localparam logic [OP_W-1:0] OP_LBI   = 5'b11000;
    localparam logic [OP_W-1:0] OP_BTR   = 5'b11001;
    localparam logic [OP_W-1:0] OP_SHFT  = 5'b11010;
    localparam logic [OP_W-1:0] OP_ARITH = 5'b11011;
    localparam logic [OP_W-1:0] OP_SEQ   = 5'b11100;
    localparam logic [OP_W-1:0] OP_SLT   = 5'b11101;
    localparam logic [OP_W-1:0] OP_SLE   = 5'b11110;
    localparam logic [OP_W-1:0] OP_SCO   = 5'b11111;

    // Bundle bit offsets (LSB of each field)
    localparam int OFS_WREG    = 0;
    localparam int OFS_RWRITE  = 3;
    localparam int OFS_ALUSRC  = 4;
    localparam int OFS_M2R     = 5;
    localparam int OFS_ALUF    = 6;
    localparam int OFS_ALUOP   = 8;
    localparam int OFS_MWRITE  = 13;
    localparam int OFS_MREAD   = 14;
    localparam int OFS_BRANCH  = 15;
    localparam int OFS_JUMP    = 16;
    localparam int OFS_REGDST  = 17;
    localparam int OFS_ZEROEX  = 19;
    localparam int OFS_SIZE    = 20;

    // reg_dst: which instruction field names the written register
    localparam logic [1:0] RD_RT   = 2'b00; // inst[7:5]
    localparam logic [1:0] RD_RD   = 2'b01; // inst[4:2]
    localparam logic [1:0] RD_RS   = 2'b10; // inst[10:8]
    localparam logic [1:0] RD_LINK = 2'b11; // r7

    // size: width of the immediate/displacement field
    localparam logic [1:0] SZ_5  = 2'b00;
    localparam logic [1:0] SZ_8  = 2'b01;
    localparam logic [1:0] SZ_11 = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    typedef struct packed {
        logic [1:0]        size;
        logic              zero_ex;
        logic [1:0]        reg_dst;
        logic              jump;
        logic              branch;
        logic              mem_read;
        logic              mem_write;
        logic [OP_W-1:0]   alu_op;
        logic [1:0]        alu_f;
        logic              mem_to_reg;
        logic              alu_src;
        logic              reg_write;
        logic [WREG_W-1:0] wreg;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational WISC instruction decoder: inst -> control bundle.
// Ports: inst (ID instruction), ctrl (bundle), illegal (trap op).
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int INST_W = 16,
    parameter int REG_AW = 3
) (
    input  logic [INST_W-1:0] inst,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal
);

    logic [OP_W-1:0] op;
    ctrl_t           c;

    assign op   = inst[INST_W-1 -: OP_W];
    assign ctrl = c;

    always_comb begin
        c        = '0;
        illegal  = 1'b0;
        c.alu_op = op;
        unique case (op)
            OP_HALT, OP_NOP: begin
            end
            OP_SIIC, OP_RTI: begin
                illegal = 1'b1;
            end
            OP_ADDI, OP_SUBI,
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_XORI, OP_ANDNI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.zero_ex   = 1'b1;
            end
            OP_ST: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_LD: begin
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            OP_STU: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.reg_write = 1'b1;
                c.reg_dst   = RD_RS;
            end
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
                c.branch = 1'b1;
                c.size   = SZ_8;
            end
            OP_LBI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.reg_dst   = RD_RS;
                c.size      = SZ_8;
            end
            OP_SLBI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.reg_dst   = RD_RS;
                c.size      = SZ_8;
                c.zero_ex   = 1'b1;
            end
            OP_J: begin
                c.jump = 1'b1;
                c.size = SZ_11;
            end
            OP_JR: begin
                c.jump    = 1'b1;
                c.alu_src = 1'b1;
                c.size    = SZ_8;
            end
            OP_JAL: begin
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
                c.reg_dst   = RD_LINK;
                c.size      = SZ_11;
            end
            OP_JALR: begin
                c.jump      = 1'b1;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.reg_dst   = RD_LINK;
                c.size      = SZ_8;
            end
            OP_BTR, OP_SHFT, OP_ARITH,
            OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                c.reg_write = 1'b1;
                c.reg_dst   = RD_RD;
                c.alu_f     = inst[1:0];
                // ANDN is the fourth ARITH function
                c.zero_ex   = (op == OP_ARITH)
                            && (inst[1:0] == 2'b11);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        if (illegal) begin
            c = '0;
        end

        // Destination index only matters when a register is written
        if (c.reg_write) begin
            unique case (c.reg_dst)
                RD_RT:   c.wreg = inst[7:5];
                RD_RD:   c.wreg = inst[4:2];
                RD_RS:   c.wreg = inst[10:8];
                default: c.wreg = {REG_AW{1'b1}};
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// WISC control pipeline: decode, EX/MEM/.../WB control stages,
// load-use hazard, memory stall, flush, illegal trap, halt drain.
// Ports: clk, rst (sync, active-high), inst/inst_valid (ID),
// stall_in, flush; ex/mem/wb ctrl+valid; id_stall, illegal_op,
// halt_done, dump.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int INST_W      = 16,
    parameter int REG_AW      = 3,
    parameter int CHAIN_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst,
    input  logic              inst_valid,
    input  logic              stall_in,
    input  logic              flush,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic              mem_valid,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic              wb_valid,
    output logic              id_stall,
    output logic              illegal_op,
    output logic              halt_done,
    output logic              dump
);

    ctrl_t            st_ctrl  [1:CHAIN_DEPTH];
    logic             st_valid [1:CHAIN_DEPTH];

    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic [OP_W-1:0]  id_op;
    logic             uses_rt;
    logic             hazard;
    logic             accept;
    logic             s1_valid;
    ctrl_t            s1_ctrl;
    logic             halt_in_ex;
    logic             halt_in_wb;
    state_t           state;
    state_t           state_nx;
    logic             dump_nx;
    logic             illegal_nx;

    ctrl_decode #(
        .INST_W (INST_W),
        .REG_AW (REG_AW)
    ) u_dec (
        .inst    (inst),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign id_op = inst[INST_W-1 -: OP_W];

    // R-format (except LBI) and ST/STU also read inst[7:5]
    assign uses_rt = ((id_op[4:3] == 2'b11) && (id_op != OP_LBI))
                   || (id_op == OP_ST) || (id_op == OP_STU);

    assign hazard = st_valid[1] && st_ctrl[1].mem_read
                 && inst_valid
                 && ((st_ctrl[1].wreg == inst[10:8])
                  || (uses_rt && (st_ctrl[1].wreg == inst[7:5])));

    assign accept = inst_valid && !stall_in && !flush
                 && !hazard && (state == ST_RUN);

    assign s1_valid   = accept && !dec_illegal;
    assign s1_ctrl    = s1_valid ? dec_ctrl : '0;
    assign illegal_nx = accept && dec_illegal;

    assign halt_in_ex = st_valid[1]
                     && (st_ctrl[1].alu_op == OP_HALT);
    assign halt_in_wb = st_valid[CHAIN_DEPTH]
                     && (st_ctrl[CHAIN_DEPTH].alu_op == OP_HALT);

    always_comb begin
        state_nx = state;
        dump_nx  = 1'b0;
        if (!stall_in) begin
            unique case (state)
                ST_RUN: begin
                    if (accept && (id_op == OP_HALT)) begin
                        state_nx = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (flush && halt_in_ex) begin
                        state_nx = ST_RUN;
                    end else if (halt_in_wb) begin
                        state_nx = ST_HALTED;
                        dump_nx  = 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_nx = ST_HALTED;
                end
                default: begin
                    state_nx = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            illegal_op <= 1'b0;
            dump       <= 1'b0;
        end else begin
            state      <= state_nx;
            illegal_op <= illegal_nx;
            dump       <= dump_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= CHAIN_DEPTH; k++) begin
                st_ctrl[k]  <= '0;
                st_valid[k] <= 1'b0;
            end
        end else if (!stall_in) begin
            st_ctrl[1]  <= s1_ctrl;
            st_valid[1] <= s1_valid;
            for (int k = 2; k <= CHAIN_DEPTH; k++) begin
                st_ctrl[k]  <= st_ctrl[k-1];
                st_valid[k] <= st_valid[k-1];
            end
        end
    end

    assign ex_ctrl   = st_ctrl[1];
    assign ex_valid  = st_valid[1];
    assign mem_ctrl  = st_ctrl[2];
    assign mem_valid = st_valid[2];
    assign wb_ctrl   = st_ctrl[CHAIN_DEPTH];
    assign wb_valid  = st_valid[CHAIN_DEPTH];
    assign id_stall  = hazard || (state != ST_RUN);
    assign halt_done = (state == ST_HALTED);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios with
// literal expectations plus a randomized run against a model.
module tb_ctrl_pipe;

    localparam int D = 3;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic [21:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic        ex_valid, mem_valid, wb_valid;
    logic        id_stall, illegal_op, halt_done, dump;

    always #5 clk = ~clk;

    ctrl_pipe #(.INST_W(16), .REG_AW(3), .CHAIN_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .inst(inst),
        .inst_valid(inst_valid), .stall_in(stall_in),
        .flush(flush), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
        .mem_ctrl(mem_ctrl), .mem_valid(mem_valid),
        .wb_ctrl(wb_ctrl), .wb_valid(wb_valid),
        .id_stall(id_stall), .illegal_op(illegal_op),
        .halt_done(halt_done), .dump(dump)
    );

    int checks = 0;
    int fails  = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        logic [21:0] c;
    } ent_t;

    ent_t pipe[$];
    int   mode = M_RUN;
    bit   m_ill = 0;
    bit   m_dump = 0;

    // Bundle straight from the ISA description, grouped by class
    function automatic logic [21:0] ref_decode(
        input logic [15:0] i, output bit ill);
        logic [4:0] op;
        bit i1, rf, brn, lnk, ld, st, stu, lbi, slbi, jr, jalr;
        bit ze, jmp, mr, mw, m2r, as, rw;
        logic [1:0] sz, rd, f;
        logic [2:0] w;
        op   = i[15:11];
        ill  = (op == 5'b00010) || (op == 5'b00011);
        i1   = op inside {5'b01000, 5'b01001, 5'b01010, 5'b01011,
                          5'b10100, 5'b10101, 5'b10110, 5'b10111};
        rf   = (op[4:3] == 2'b11) && (op != 5'b11000);
        brn  = (op[4:2] == 3'b011);
        jmp  = (op[4:2] == 3'b001);
        lnk  = (op == 5'b00110) || (op == 5'b00111);
        jr   = (op == 5'b00101);
        jalr = (op == 5'b00111);
        ld   = (op == 5'b10001);
        st   = (op == 5'b10000);
        stu  = (op == 5'b10011);
        lbi  = (op == 5'b11000);
        slbi = (op == 5'b10010);
        mr   = ld;
        mw   = st || stu;
        m2r  = ld;
        rw   = i1 || ld || stu || rf || lbi || slbi || lnk;
        as   = i1 || ld || st || stu || lbi || slbi || jr || jalr;
        rd   = lnk ? 2'd3 : (stu || lbi || slbi) ? 2'd2
             : rf ? 2'd1 : 2'd0;
        sz   = (op == 5'b00100 || op == 5'b00110) ? 2'd2
             : (brn || lbi || slbi || jr || jalr) ? 2'd1 : 2'd0;
        ze   = (op == 5'b01010) || (op == 5'b01011) || slbi
             || (op == 5'b11011 && i[1:0] == 2'b11);
        f    = rf ? i[1:0] : 2'b00;
        if (!rw)          w = 3'd0;
        else if (rd == 0) w = i[7:5];
        else if (rd == 1) w = i[4:2];
        else if (rd == 2) w = i[10:8];
        else              w = 3'd7;
        if (ill) return '0;
        return {sz, ze, rd, jmp, brn, mr, mw, op, f, m2r, as, rw, w};
    endfunction

    function automatic bit load_use(input ent_t ex, input logic iv,
                                    input logic [15:0] i);
        bit rt_src;
        rt_src = (i[15:14] == 2'b11 && i[15:11] != 5'b11000)
              || (i[15:11] == 5'b10000) || (i[15:11] == 5'b10011);
        return ex.v && ex.c[14] && iv
            && (ex.c[2:0] == i[10:8]
             || (rt_src && ex.c[2:0] == i[7:5]));
    endfunction

    function automatic ent_t bubble();
        ent_t z;
        z.v = 1'b0;
        z.c = '0;
        return z;
    endfunction

    initial begin
        for (int k = 0; k < D; k++) pipe.push_back(bubble());
    end

    always @(posedge clk) begin
        ent_t e;
        bit ill, take;
        logic [21:0] d;
        if (rst) begin
            pipe = {};
            for (int k = 0; k < D; k++) pipe.push_back(bubble());
            mode = M_RUN;
            m_ill = 0;
            m_dump = 0;
        end else if (stall_in) begin
            m_ill = 0;
            m_dump = 0;
        end else begin
            d = ref_decode(inst, ill);
            take = inst_valid && !flush && mode == M_RUN
                && !load_use(pipe[0], inst_valid, inst);
            m_ill = take && ill;
            m_dump = 0;
            if (mode == M_RUN && take && inst[15:11] == 5'b0)
                mode = M_DRAIN;
            else if (mode == M_DRAIN && flush && pipe[0].v
                     && pipe[0].c[12:8] == 5'b0)
                mode = M_RUN;
            else if (mode == M_DRAIN && pipe[D-1].v
                     && pipe[D-1].c[12:8] == 5'b0) begin
                mode = M_HALTED;
                m_dump = 1;
            end
            e.v = take && !ill;
            e.c = e.v ? d : '0;
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
    end

    // Compare every cycle, mid-period, once the model is anchored
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ex_ctrl",   ex_ctrl,   pipe[0].c);
            chk("m_ex_valid",  ex_valid,  pipe[0].v);
            chk("m_mem_ctrl",  mem_ctrl,  pipe[1].c);
            chk("m_mem_valid", mem_valid, pipe[1].v);
            chk("m_wb_ctrl",   wb_ctrl,   pipe[D-1].c);
            chk("m_wb_valid",  wb_valid,  pipe[D-1].v);
            chk("m_illegal",   illegal_op, m_ill);
            chk("m_dump",      dump,      m_dump);
            chk("m_halt_done", halt_done, mode == M_HALTED);
            chk("m_id_stall",  id_stall,
                load_use(pipe[0], inst_valid, inst)
                || mode != M_RUN);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic iv,
                         input logic [15:0] i, input logic s,
                         input logic f);
        rst = r;
        inst_valid = iv;
        inst = i;
        stall_in = s;
        flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    localparam logic [15:0] I_ADDI = 16'h4225;
    localparam logic [15:0] I_LD   = 16'h8960;
    localparam logic [15:0] I_ADD  = 16'hDB50;
    localparam logic [15:0] I_SIIC = 16'h1000;
    localparam logic [15:0] I_HALT = 16'h0000;
    localparam logic [21:0] C_ADDI = 22'h000819;
    localparam logic [21:0] C_LD   = 22'h00513B;
    localparam logic [21:0] C_ADD  = 22'h021B0C;

    initial begin
        logic [15:0] r;
        drive(1, 0, '0, 0, 0);
        tick();
        chk_en = 1;
        tick();
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_id_stall", id_stall, 0);
        chk("rst_halt_done", halt_done, 0);
        chk("rst_dump", dump, 0);
        chk("rst_illegal", illegal_op, 0);

        // ADDI flows through all stages
        drive(0, 1, I_ADDI, 0, 0);
        tick();
        drive(0, 0, '0, 0, 0);
        chk("addi_ex_ctrl", ex_ctrl, C_ADDI);
        chk("addi_ex_valid", ex_valid, 1);
        tick();
        chk("addi_mem_valid", mem_valid, 1);
        tick();
        chk("addi_wb_valid", wb_valid, 1);
        chk("addi_wb_ctrl", wb_ctrl, C_ADDI);

        // Load-use: LD r3 then ADD reading r3
        drive(0, 1, I_LD, 0, 0);
        tick();
        chk("ld_ex_ctrl", ex_ctrl, C_LD);
        drive(0, 1, I_ADD, 0, 0);
        #1;
        chk("lu_id_stall", id_stall, 1);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_mem_ctrl", mem_ctrl, C_LD);
        #1;
        chk("lu_released", id_stall, 0);
        tick();
        chk("lu_add_ctrl", ex_ctrl, C_ADD);
        chk("lu_add_valid", ex_valid, 1);

        // Memory stall with a flush inside it
        drive(0, 1, I_ADDI, 0, 0);
        tick();
        drive(0, 1, I_LD, 1, 0);
        tick();
        drive(0, 1, I_LD, 1, 1);
        tick();
        drive(0, 1, I_LD, 1, 0);
        tick();
        chk("stall_ex_ctrl", ex_ctrl, C_ADDI);
        chk("stall_mem_ctrl", mem_ctrl, C_ADD);
        drive(0, 1, I_LD, 0, 1);
        tick();
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_mem_ctrl", mem_ctrl, C_ADDI);

        // Illegal op trap and its suppression by flush
        drive(0, 1, I_SIIC, 0, 0);
        tick();
        chk("siic_pulse", illegal_op, 1);
        chk("siic_bubble", ex_valid, 0);
        drive(0, 0, '0, 0, 0);
        tick();
        chk("siic_one_cycle", illegal_op, 0);
        drive(0, 1, I_SIIC, 0, 1);
        tick();
        chk("siic_flushed", illegal_op, 0);

        // HALT drain
        drive(0, 1, I_HALT, 0, 0);
        tick();
        chk("halt_ex_valid", ex_valid, 1);
        chk("halt_ex_ctrl", ex_ctrl, 0);
        drive(0, 1, I_ADDI, 0, 0);
        #1;
        chk("halt_id_stall", id_stall, 1);
        tick();
        chk("drain_ex_valid", ex_valid, 0);
        chk("drain_dump_early", dump, 0);
        tick();
        tick();
        chk("halt_dump", dump, 1);
        chk("halt_done_set", halt_done, 1);
        tick();
        chk("halt_dump_once", dump, 0);
        chk("halt_done_hold", halt_done, 1);

        // Reset in the middle of a drain
        drive(1, 0, '0, 0, 0);
        tick();
        drive(0, 1, I_HALT, 0, 0);
        tick();
        drive(1, 0, '0, 0, 0);
        tick();
        chk("rdr_ex_valid", ex_valid, 0);
        chk("rdr_id_stall", id_stall, 0);
        chk("rdr_halt_done", halt_done, 0);
        drive(0, 1, I_ADDI, 0, 0);
        tick();
        chk("rdr_addi", ex_ctrl, C_ADDI);

        // Randomized traffic, loads biased up to provoke hazards
        for (int n = 0; n < 4000; n++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 3) == 0) r[15:11] = 5'b10001;
            drive($urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 8, r,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0);
            tick();
        end
        drive(0, 0, '0, 0, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
